// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regwb_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } wbarb_state_t;

    localparam int NUM_REGS = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from (ptr+1) mod N and
// returns a one-hot grant plus the granted index.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IDX_W'((int'(ptr) + k) % N);
            if (!grant_valid && req[w_idx]) begin
                grant_valid  = 1'b1;
                grant_idx    = w_idx;
                grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter plus r1..r31 clear sweep for the register file.
// Optional busy scoreboard enabled by defining WBARB_SCOREBOARD_EN.
module regfile_wb_arbiter
    import regwb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      clr_req,
    output logic                      clr_busy,
    output logic                      clr_done,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         write_register,
    output logic [DATA_W-1:0]         write_data
`ifdef WBARB_SCOREBOARD_EN
    ,
    input  logic                      iss_valid,
    input  logic [ADDR_W-1:0]         iss_addr,
    output logic [NUM_REGS-1:0]       busy_mask
`endif
);

    localparam int IDX_W = $clog2(N_REQ);

    wbarb_state_t      r_state;
    wbarb_state_t      w_state_next;
    reg_addr_t         r_sweep_cnt;
    logic [IDX_W-1:0]  r_ptr;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_wr_reg;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_clr_done;

    logic [ADDR_W-1:0] w_req_addr [N_REQ];
    logic [DATA_W-1:0] w_req_data [N_REQ];
    logic [N_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_grant_valid;
    logic              w_arb_open;
    logic              w_accept;
    logic              w_sweep_last;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_req_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_req_data[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (r_ptr),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    assign w_sweep_last = (r_sweep_cnt == reg_addr_t'(NUM_REGS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB:     if (clr_req) w_state_next = CLEAR;
            CLEAR:   if (w_sweep_last) w_state_next = ARB;
            default: w_state_next = ARB;
        endcase
    end

    // A pending clear request blocks every grant, and nothing is offered while reset is low.
    always_comb begin
        w_arb_open = rst && (r_state == ARB) && !clr_req;
        req_ready  = w_arb_open ? w_grant : '0;
        w_accept   = w_arb_open && w_grant_valid;
        clr_busy   = (r_state == CLEAR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sweep_cnt <= '0;
            r_ptr       <= IDX_W'(N_REQ - 1);
        end else begin
            if (r_state == ARB && clr_req) begin
                r_sweep_cnt <= reg_addr_t'(1);
            end else if (r_state == CLEAR) begin
                r_sweep_cnt <= r_sweep_cnt + reg_addr_t'(1);
            end
            if (w_accept) begin
                r_ptr <= w_grant_idx;
            end
        end
    end

    // r0 accepts are real handshakes; only the enable is suppressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write <= 1'b0;
            r_wr_reg    <= '0;
            r_wr_data   <= '0;
            r_clr_done  <= 1'b0;
        end else begin
            r_clr_done <= (r_state == CLEAR) && w_sweep_last;
            if (w_accept) begin
                r_reg_write <= (w_req_addr[w_grant_idx] != '0);
                r_wr_reg    <= w_req_addr[w_grant_idx];
                r_wr_data   <= w_req_data[w_grant_idx];
            end else if (r_state == CLEAR) begin
                r_reg_write <= 1'b1;
                r_wr_reg    <= ADDR_W'(r_sweep_cnt);
                r_wr_data   <= '0;
            end else begin
                r_reg_write <= 1'b0;
            end
        end
    end

    assign RegWrite       = r_reg_write;
    assign write_register = r_wr_reg;
    assign write_data     = r_wr_data;
    assign clr_done       = r_clr_done;

`ifdef WBARB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] r_busy;

    // Issue beats a same-cycle commit to the same register.
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_busy[gi] <= 1'b0;
                end else if (r_state == CLEAR) begin
                    r_busy[gi] <= 1'b0;
                end else if ((gi != 0) && iss_valid && (iss_addr == ADDR_W'(gi))) begin
                    r_busy[gi] <= 1'b1;
                end else if (r_reg_write && (r_wr_reg == ADDR_W'(gi))) begin
                    r_busy[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign busy_mask = r_busy;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic compared against a cycle-level reference model of the write port.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;
    logic        RegWrite;
    logic [4:0]  write_register;
    logic [31:0] write_data;
`ifdef WBARB_SCOREBOARD_EN
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [31:0] busy_mask;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .N_REQ  (3),
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .clr_req        (clr_req),
        .clr_busy       (clr_busy),
        .clr_done       (clr_done),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data)
`ifdef WBARB_SCOREBOARD_EN
        ,
        .iss_valid      (iss_valid),
        .iss_addr       (iss_addr),
        .busy_mask      (busy_mask)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: last winner, sweep position, and what the write port shows now.
    int          m_ptr;
    bit          m_sweep;
    int          m_cnt;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_done;
    logic [31:0] m_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 2;
        m_sweep = 1'b0;
        m_cnt   = 0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_done  = 1'b0;
        m_busy  = '0;
    endtask

    // Called at posedge+1: drive inputs, check at negedge, step the model after the edge.
    task automatic cycle(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d, input logic c);
        int          g;
        int          i;
        logic [2:0]  exp_ready;
        logic [4:0]  ga;
        logic [31:0] gd;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        clr_req   = c;
        @(negedge clk);
        g = -1;
        if (!m_sweep && !c) begin
            for (int k = 1; k <= 3; k++) begin
                i = (m_ptr + k) % 3;
                if (g < 0 && ((v >> i) & 3'd1) != 3'd0) g = i;
            end
        end
        exp_ready = (g >= 0) ? (3'b001 << g) : 3'b000;
        check("ready", 64'(req_ready), 64'(exp_ready));
        check("clr_busy", 64'(clr_busy), 64'(m_sweep));
        check("clr_done", 64'(clr_done), 64'(m_done));
        check("regwrite", 64'(RegWrite), 64'(m_we));
        check("wr_reg", 64'(write_register), 64'(m_waddr));
        check("wr_data", 64'(write_data), 64'(m_wdata));
`ifdef WBARB_SCOREBOARD_EN
        check("busy_mask", 64'(busy_mask), 64'(m_busy));
`endif
        if (m_we) $display("[TB] t=%0t write r%0d <= %08h", $time, m_waddr, m_wdata);
        @(posedge clk);
        #1;
`ifdef WBARB_SCOREBOARD_EN
        if (m_sweep) begin
            m_busy = '0;
        end else begin
            if (m_we) m_busy[m_waddr] = 1'b0;
            if (iss_valid && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
        end
`endif
        ga = 5'(a >> (g * 5));
        gd = 32'(d >> (g * 32));
        m_done = 1'b0;
        if (m_sweep) begin
            m_we    = 1'b1;
            m_waddr = 5'(m_cnt);
            m_wdata = '0;
            if (m_cnt == 31) begin
                m_sweep = 1'b0;
                m_done  = 1'b1;
            end else begin
                m_cnt++;
            end
        end else if (c) begin
            m_sweep = 1'b1;
            m_cnt   = 1;
            m_we    = 1'b0;
        end else if (g >= 0) begin
            m_ptr   = g;
            m_we    = (ga != 5'd0);
            m_waddr = ga;
            m_wdata = gd;
        end else begin
            m_we = 1'b0;
        end
    endtask

    initial begin
        int guard;
        int done_seen;
        rst       = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'h33, 32'h22, 32'h11};
        clr_req   = 1'b0;
`ifdef WBARB_SCOREBOARD_EN
        iss_valid = 1'b0;
        iss_addr  = '0;
`endif
        model_reset();

        // Reset holds everything quiet even with all requesters valid.
        #12;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_wr_reg", 64'(write_register), 64'd0);
        check("rst_wr_data", 64'(write_data), 64'd0);
        check("rst_busy", 64'(clr_busy), 64'd0);
        check("rst_done", 64'(clr_done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // All valid: rotates 0,1,2,0,1,2.
        for (int n = 0; n < 6; n++) cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 1'b0);

        // req1 alone to r8.
        cycle(3'b010, {5'd0, 5'd8, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 1'b0);
        check("t3_regwrite", 64'(RegWrite), 64'd1);
        check("t3_wr_reg", 64'(write_register), 64'd8);
        check("t3_wr_data", 64'(write_data), 64'hDEADBEEF);

        // r0 write is accepted but not enabled.
        cycle(3'b001, 15'd0, {64'h0, 32'd5}, 1'b0);
        check("t4_regwrite", 64'(RegWrite), 64'd0);
        check("t4_wr_data", 64'(write_data), 64'd5);
        cycle(3'b000, 15'd0, 96'd0, 1'b0);

        // Full sweep with req2 waiting, then req2 gets in.
        done_seen = 0;
        cycle(3'b100, {5'd7, 10'd0}, {32'h77, 64'd0}, 1'b1);
        for (int n = 0; n < 33; n++) begin
            if (clr_done) done_seen++;
            cycle(3'b100, {5'd7, 10'd0}, {32'h77, 64'd0}, 1'b0);
        end
        check("t5_done_count", 64'(done_seen), 64'd1);
        cycle(3'b000, 15'd0, 96'd0, 1'b0);

        // Reset mid-sweep around r10.
        cycle(3'b000, 15'd0, 96'd0, 1'b1);
        guard = 0;
        while (!(m_sweep && m_cnt == 10) && guard < 40) begin
            cycle(3'b011, {5'd0, 5'd4, 5'd9}, {32'h0, 32'h44, 32'h99}, 1'b0);
            guard++;
        end
        check("t5_sweep_reach", 64'(guard < 40), 64'd1);
        rst = 1'b0;
        #2;
        check("t5_rst_regwrite", 64'(RegWrite), 64'd0);
        check("t5_rst_busy", 64'(clr_busy), 64'd0);
        check("t5_rst_ready", 64'(req_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int n = 0; n < 4; n++) cycle(3'b011, {5'd0, 5'd4, 5'd9}, {32'h0, 32'h44, 32'h99}, 1'b0);

`ifdef WBARB_SCOREBOARD_EN
        iss_valid = 1'b1;
        iss_addr  = 5'd5;
        cycle(3'b000, 15'd0, 96'd0, 1'b0);
        iss_valid = 1'b0;
        cycle(3'b001, 15'd5, {64'd0, 32'h55}, 1'b0);
        cycle(3'b000, 15'd0, 96'd0, 1'b0);
        cycle(3'b001, 15'd5, {64'd0, 32'h56}, 1'b0);
        iss_valid = 1'b1;
        cycle(3'b000, 15'd0, 96'd0, 1'b0);
        iss_valid = 1'b0;
        cycle(3'b000, 15'd0, 96'd0, 1'b0);
`endif

        // Random traffic, occasional sweeps and r0 targets.
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  rv;
            logic [14:0] ra;
            logic [95:0] rd;
            logic        rc;
            rv = 3'($urandom);
            ra = 15'($urandom);
            if ($urandom_range(0, 7) == 0) ra[4:0] = 5'd0;
            rd = {$urandom, $urandom, $urandom};
            rc = ($urandom_range(0, 59) == 0);
`ifdef WBARB_SCOREBOARD_EN
            iss_valid = 1'($urandom);
            iss_addr  = 5'($urandom);
`endif
            cycle(rv, ra, rd, rc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
